// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if -- issue-side bundle between decode and the register scoreboard.
//   master : decode/pipeline control; drives freeze/flush and the decode-stage instruction
//            fields, and receives stall, forwarding selects and busy_vec.
//   slave  : the scoreboard; the mirror image of master.
interface reg_scoreboard_if;
  logic       freeze;
  logic       flush;
  logic       iss_valid;
  logic       iss_regWrite;
  logic       iss_isLoad;
  logic [2:0] iss_writeReg;
  logic [2:0] iss_rs;
  logic [2:0] iss_rt;
  logic       iss_rs_rd;
  logic       iss_rt_rd;
  logic       stall;
  logic [1:0] fwd_sel_A;
  logic [1:0] fwd_sel_B;
  logic [7:0] busy_vec;

  modport master (
    output freeze, flush, iss_valid, iss_regWrite, iss_isLoad,
           iss_writeReg, iss_rs, iss_rt, iss_rs_rd, iss_rt_rd,
    input  stall, fwd_sel_A, fwd_sel_B, busy_vec
  );

  modport slave (
    input  freeze, flush, iss_valid, iss_regWrite, iss_isLoad,
           iss_writeReg, iss_rs, iss_rt, iss_rs_rd, iss_rt_rd,
    output stall, fwd_sel_A, fwd_sel_B, busy_vec
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- tracks the youngest in-flight writer of each of 8 registers and
// derives load-use stall, operand forwarding selects and a busy vector for decode.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   sb       : reg_scoreboard_if.slave (freeze, flush, decode fields in; stall,
//              fwd_sel_A/B, busy_vec out)
// Per register: age 3 = producer in X, 2 = in M, 1 = in W, 0 = idle; plus a load flag.
// Forwarding select: 00 regfile, 01 XM aluOut, 10 MW result, 11 WB writeData latch.
// Build option: define SCB_WB_BYPASS_EN when the regfile does write-before-read, so a
// producer in W (age 1) is read from the regfile (00) instead of the WB latch (11).

// One register's tracking entry.
module scb_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze_i,
  input  logic       cap_i,
  input  logic       cap_ld_i,
  output logic [1:0] age_o,
  output logic       ld_o
);
  logic [1:0] age_q, age_d;
  logic       ld_q,  ld_d;

  always_comb begin
    age_d = age_q;
    ld_d  = ld_q;
    if (!freeze_i) begin
      if (cap_i) begin
        // Youngest writer wins: any older in-flight entry is overwritten.
        age_d = 2'd3;
        ld_d  = cap_ld_i;
      end else if (age_q != 2'd0) begin
        age_d = age_q - 2'd1;
        if (age_q == 2'd1) ld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= 2'd0;
      ld_q  <= 1'b0;
    end else begin
      age_q <= age_d;
      ld_q  <= ld_d;
    end
  end

  assign age_o = age_q;
  assign ld_o  = ld_q;
endmodule

module reg_scoreboard (
  input  logic             clk,
  input  logic             rst_n,
  reg_scoreboard_if.slave  sb
);
  localparam int NUM_REGS = 8;

`ifdef SCB_WB_BYPASS_EN
  localparam logic [1:0] SEL_AGE1 = 2'b00;
`else
  localparam logic [1:0] SEL_AGE1 = 2'b11;
`endif

  logic [NUM_REGS-1:0][1:0] age;
  logic [NUM_REGS-1:0]      ld;
  logic [NUM_REGS-1:0]      cap_vec;
  logic                     capture;
  logic                     ld_hit_rs, ld_hit_rt;

  // Load still in X with a dependent reader in decode: one bubble. Stall also blocks
  // the capture, so the held instruction is captured when it re-issues.
  assign ld_hit_rs = sb.iss_rs_rd && (age[sb.iss_rs] == 2'd3) && ld[sb.iss_rs];
  assign ld_hit_rt = sb.iss_rt_rd && (age[sb.iss_rt] == 2'd3) && ld[sb.iss_rt];
  assign sb.stall  = sb.iss_valid && (ld_hit_rs || ld_hit_rt);

  assign capture = sb.iss_valid && sb.iss_regWrite && !sb.stall && !sb.flush && !sb.freeze;

  genvar n;
  generate
    for (n = 0; n < NUM_REGS; n++) begin : g_ent
      assign cap_vec[n] = capture && (sb.iss_writeReg == 3'(n));

      scb_entry u_ent (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze_i (sb.freeze),
        .cap_i    (cap_vec[n]),
        .cap_ld_i (sb.iss_isLoad),
        .age_o    (age[n]),
        .ld_o     (ld[n])
      );

      assign sb.busy_vec[n] = (age[n] != 2'd0);
    end
  endgenerate

  // Selects come from pre-edge state, so a source equal to iss_writeReg sees the
  // previous writer, not the instruction being captured.
  function automatic logic [1:0] sel_for(input logic rd, input logic [1:0] a);
    logic [1:0] s;
    s = 2'b00;
    if (rd) begin
      case (a)
        2'd3:    s = 2'b01;
        2'd2:    s = 2'b10;
        2'd1:    s = SEL_AGE1;
        default: s = 2'b00;
      endcase
    end
    return s;
  endfunction

  assign sb.fwd_sel_A = sel_for(sb.iss_rs_rd, age[sb.iss_rs]);
  assign sb.fwd_sel_B = sel_for(sb.iss_rt_rd, age[sb.iss_rt]);
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef SCB_WB_BYPASS_EN
  localparam logic [1:0] AGE1 = 2'b00;
`else
  localparam logic [1:0] AGE1 = 2'b11;
`endif

  reg_scoreboard_if sbif ();

  reg_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic l, input logic [2:0] wr,
                       input logic rsr, input logic [2:0] rs,
                       input logic rtr, input logic [2:0] rt);
    sbif.iss_valid    = v;
    sbif.iss_regWrite = w;
    sbif.iss_isLoad   = l;
    sbif.iss_writeReg = wr;
    sbif.iss_rs_rd    = rsr;
    sbif.iss_rs       = rs;
    sbif.iss_rt_rd    = rtr;
    sbif.iss_rt       = rt;
  endtask

  // Advance one clock; inputs change 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sbif.freeze = 1'b0;
    sbif.flush  = 1'b0;
    drive(1, 0, 0, 0, 1, 3, 1, 2);
    #12;
    chk("reset_busy",  sbif.busy_vec, 8'h00);
    chk("reset_stall", 8'(sbif.stall), 8'h00);
    chk("reset_selA",  8'(sbif.fwd_sel_A), 8'h00);
    chk("reset_selB",  8'(sbif.fwd_sel_B), 8'h00);
    rst_n = 1'b1;

    // Back-to-back ALU on R3
    drive(1, 1, 0, 3, 0, 0, 0, 0);
    #1 chk("alu_pre_busy", sbif.busy_vec, 8'h00);
    cyc();
    drive(1, 0, 0, 0, 1, 3, 0, 0);
    #1 chk("alu_x_selA", 8'(sbif.fwd_sel_A), 8'h01);
    chk("alu_x_stall", 8'(sbif.stall), 8'h00);
    chk("alu_x_busy",  sbif.busy_vec, 8'h08);
    cyc();
    #1 chk("alu_m_selA", 8'(sbif.fwd_sel_A), 8'h02);
    cyc();
    #1 chk("alu_w_selA", 8'(sbif.fwd_sel_A), 8'(AGE1));
    chk("alu_w_busy", sbif.busy_vec, 8'h08);
    cyc();
    #1 chk("alu_idle_selA", 8'(sbif.fwd_sel_A), 8'h00);
    chk("alu_idle_busy", sbif.busy_vec, 8'h00);

    // Load-use on R2; the stalled reader also tries to write R6 (must not capture)
    drive(1, 1, 1, 2, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 0, 6, 0, 0, 1, 2);
    #1 chk("lu_stall", 8'(sbif.stall), 8'h01);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 1, 2);
    #1 chk("lu_after_stall", 8'(sbif.stall), 8'h00);
    chk("lu_selB", 8'(sbif.fwd_sel_B), 8'h02);
    chk("lu_busy_m", sbif.busy_vec, 8'h04);
    cyc();
    idle();
    #1 chk("lu_busy_w", sbif.busy_vec, 8'h04);
    cyc();
    #1 chk("lu_busy_clr", sbif.busy_vec, 8'h00);

    // ADDI R1,R1,1 twice: second resolves against the first, then is recaptured
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 0, 1, 1, 1, 0, 0);
    #1 chk("self_selA", 8'(sbif.fwd_sel_A), 8'h01);
    chk("self_stall", 8'(sbif.stall), 8'h00);
    cyc();
    drive(1, 0, 0, 0, 1, 1, 1, 1);
    #1 chk("recap_selA", 8'(sbif.fwd_sel_A), 8'h01);
    chk("same_src_selB", 8'(sbif.fwd_sel_B), 8'h01);
    idle();
    cyc(); cyc(); cyc();
    #1 chk("self_drain", sbif.busy_vec, 8'h00);

    // Overwrite R4 in consecutive cycles
    drive(1, 1, 0, 4, 0, 0, 0, 0);
    cyc();
    cyc();
    drive(1, 0, 0, 0, 1, 4, 0, 0);
    #1 chk("ovw_selA", 8'(sbif.fwd_sel_A), 8'h01);
    chk("ovw_busy1", sbif.busy_vec, 8'h10);
    cyc();
    idle();
    #1 chk("ovw_busy2", sbif.busy_vec, 8'h10);
    cyc();
    #1 chk("ovw_busy3", sbif.busy_vec, 8'h10);
    cyc();
    #1 chk("ovw_busy_clr", sbif.busy_vec, 8'h00);

    // Flush blocks capture
    sbif.flush = 1'b1;
    drive(1, 1, 0, 7, 0, 0, 0, 0);
    cyc();
    sbif.flush = 1'b0;
    idle();
    #1 chk("flush_busy", sbif.busy_vec, 8'h00);

    // Freeze: R5 in X held for 4 cycles, capture of R7 ignored
    drive(1, 1, 0, 5, 0, 0, 0, 0);
    cyc();
    sbif.freeze = 1'b1;
    drive(1, 1, 0, 7, 1, 5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("frz_selA", 8'(sbif.fwd_sel_A), 8'h01);
      chk("frz_busy", sbif.busy_vec, 8'h20);
      cyc();
    end
    #1 chk("frz_end_selA", 8'(sbif.fwd_sel_A), 8'h01);
    chk("frz_end_busy", sbif.busy_vec, 8'h20);
    sbif.freeze = 1'b0;
    drive(1, 0, 0, 0, 1, 5, 0, 0);
    cyc();
    #1 chk("unfrz_selA", 8'(sbif.fwd_sel_A), 8'h02);
    idle();
    cyc(); cyc();
    #1 chk("unfrz_drain", sbif.busy_vec, 8'h00);

    // WB distance: writer of R5 three cycles before the reader
    drive(1, 1, 0, 5, 0, 0, 0, 0);
    cyc();
    idle();
    cyc(); cyc();
    drive(1, 0, 0, 0, 0, 0, 1, 5);
    #1 chk("wb_selB", 8'(sbif.fwd_sel_B), 8'(AGE1));
    chk("wb_stall", 8'(sbif.stall), 8'h00);
    cyc();
    idle();

    // Reset mid-flight: R1 (age1), R2 (age2), R3 load (age3)
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 0, 2, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 1, 3, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 1, 1, 1, 2);
    #1 chk("rst_pre_busy", sbif.busy_vec, 8'h0E);
    chk("rst_pre_selA", 8'(sbif.fwd_sel_A), 8'(AGE1));
    chk("rst_pre_selB", 8'(sbif.fwd_sel_B), 8'h02);
    drive(1, 0, 0, 0, 1, 3, 1, 2);
    #1 chk("rst_pre_stall", 8'(sbif.stall), 8'h01);
    rst_n = 1'b0;
    #1 chk("rst_busy", sbif.busy_vec, 8'h00);
    chk("rst_stall", 8'(sbif.stall), 8'h00);
    chk("rst_selA", 8'(sbif.fwd_sel_A), 8'h00);
    chk("rst_selB", 8'(sbif.fwd_sel_B), 8'h00);
    rst_n = 1'b1;
    cyc();
    #1 chk("rst_post_busy", sbif.busy_vec, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 freeze  input  1  global pipeline hold (memory stall); when high, no entry state changes.
REQ-004 flush  input  1  branch/jump taken in EX; when high, the decode-stage instruction is discarded.
REQ-005 iss_valid  input  1  decode-stage instruction present.
REQ-006 iss_regWrite  input  1  decode instruction writes a register.
REQ-007 iss_isLoad  input  1  decode instruction is LD.
REQ-008 iss_writeReg  input  3  destination register of the decode instruction.
REQ-009 iss_rs, iss_rt  input  3 each  source register fields of the decode instruction.
REQ-010 iss_rs_rd, iss_rt_rd  input  1 each  the matching source is actually read.
REQ-011 stall  output  1  load-use hazard; hold F/D and inject NOP (16'h0800) into X.
REQ-012 fwd_sel_A, fwd_sel_B  output  2 each  operand source: 00 regfile, 01 XM aluOut, 10 MW result, 11 WB writeData latch.
REQ-013 busy_vec  output  8  bit n high when register n has an in-flight writer.

Function
REQ-014 The block SHALL keep, per register 0-7, a 2-bit age (0 idle, 3 producer in X, 2 in M, 1 in W) and a 1-bit load flag.
REQ-015 Capture condition SHALL be iss_valid & iss_regWrite & ~stall & ~flush & ~freeze.
REQ-016 On capture, entry[iss_writeReg] SHALL become age 3 with load flag = iss_isLoad, overwriting any older entry; only the youngest writer is tracked.
REQ-017 Each cycle with freeze low, every non-captured entry with age > 0 SHALL decrement by 1; age 0 stays 0; the load flag clears when age reaches 0.
REQ-018 When freeze is high, all ages, flags and captures SHALL hold.
REQ-019 Operand selection for source s SHALL be combinational from current (pre-edge) state: not read or age 0 -> 00; age 3 -> 01; age 2 -> 10; age 1 -> per REQ-026.
REQ-020 stall SHALL assert when iss_valid and a read source has age 3 with its load flag set; fwd_sel for that source is don't-care during stall.
REQ-021 In the stall cycle the load entry decrements to age 2 (the load moves to M), so the next cycle yields fwd_sel 10 and stall low: exactly one bubble per load-use.
REQ-022 A source equal to iss_writeReg (e.g. ADDI R1,R1,1) SHALL resolve against the pre-capture entry.
REQ-023 When both sources name the same register, both selects SHALL be identical.
REQ-024 busy_vec[n] SHALL equal (age[n] != 0), registered state only.

Reset
REQ-025 While rst_n is low, all ages and load flags SHALL clear immediately, including mid-operation; outputs SHALL then read stall=0, fwd_sel_A=fwd_sel_B=00, busy_vec=8'h00.

Configuration
REQ-026 Macro SCB_WB_BYPASS_EN: when defined, a source at age 1 SHALL select 00 (regfile provides write-before-read bypass); when undefined, it SHALL select 11 (WB writeData latch).
REQ-027 The macro SHALL affect only the age-1 select decode; stall, ages and busy_vec SHALL be identical in both builds.

Verification
REQ-028 Back-to-back ALU: ADD R3 captured, next cycle decode reads rs=R3 -> fwd_sel_A=01, stall=0; one cycle later a reader of R3 -> 10.
REQ-029 Load-use: LD R2 captured, next decode reads rt=R2 -> stall=1 for one cycle, then fwd_sel_B=10, busy_vec[2] clears after two further cycles.
REQ-030 WB distance: writer of R5 three cycles before the reader -> fwd_sel=00 with SCB_WB_BYPASS_EN, 11 without.
REQ-031 Overwrite: writers to R4 in consecutive cycles, reader immediately after -> fwd_sel=01 (youngest writer), busy_vec[4] stays set for 3 cycles after the last capture.
REQ-032 Flush and freeze: capture attempt with flush=1 -> no entry set; freeze=1 for 4 cycles -> ages and selects unchanged.
REQ-033 Reset mid-flight: three entries busy, rst_n pulsed low asynchronously -> busy_vec=8'h00, stall=0 and selects 00 before the next clock edge.
